tnoc_flit_packer: RTL and testbench

- Converts one packet into a flit stream with head/tail marking and credit-based flow control on each virtual channel.
- Input is a packet header (flat vector plus decoded type, burst length and VC) and a separate payload beat stream.
- Sits between a BFM/NIU packet source and the router input port.
- Generalises the fixed flit format in three ways: headers may span several flits, the VC count is parametrised, and per-VC credit counters gate the output.

---
 rtl/tnoc_flit_packer.sv | 200 ++++++++++++++++++++
 tb/tb_tnoc_flit_packer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnoc_flit_packer.sv
// tnoc_flit_packer: turns one packet (header + payload beat stream) into a
// head/tail-marked flit stream, gated by per-VC credit counters.
module tnoc_flit_packer #(
    parameter int unsigned VIRTUAL_CHANNELS   = 2,
    parameter int unsigned HEADER_WIDTH       = 128,
    parameter int unsigned FLIT_DATA_WIDTH    = 288,
    parameter int unsigned PAYLOAD_WIDTH      = 288,
    parameter int unsigned BURST_LENGTH_WIDTH = 8,
    parameter int unsigned CREDIT_DEPTH       = 4,
    localparam int unsigned VC_WIDTH   = (VIRTUAL_CHANNELS > 1) ? $clog2(VIRTUAL_CHANNELS) : 1,
    localparam int unsigned FLIT_WIDTH = FLIT_DATA_WIDTH + 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_header_valid,
    output logic                          o_header_ready,
    input  logic [7:0]                    i_packet_type,
    input  logic [BURST_LENGTH_WIDTH-1:0] i_burst_length,
    input  logic [VC_WIDTH-1:0]           i_vc,
    input  logic [HEADER_WIDTH-1:0]       i_header,
    input  logic                          i_payload_valid,
    output logic                          o_payload_ready,
    input  logic [PAYLOAD_WIDTH-1:0]      i_payload,
    output logic                          o_flit_valid,
    input  logic                          i_flit_ready,
    output logic [FLIT_WIDTH-1:0]         o_flit,
    output logic [VC_WIDTH-1:0]           o_vc,
    input  logic [VIRTUAL_CHANNELS-1:0]   i_credit_return
);

    localparam int unsigned HEADER_FLITS  = (HEADER_WIDTH + FLIT_DATA_WIDTH - 1) / FLIT_DATA_WIDTH;
    localparam int unsigned HDR_PAD_WIDTH = HEADER_FLITS * FLIT_DATA_WIDTH;
    localparam int unsigned HIDX_WIDTH    = (HEADER_FLITS > 1) ? $clog2(HEADER_FLITS) : 1;
    localparam int unsigned BEAT_WIDTH    = BURST_LENGTH_WIDTH + 1;
    localparam int unsigned CREDIT_WIDTH  = $clog2(CREDIT_DEPTH + 1);

    localparam logic [HIDX_WIDTH-1:0]   LAST_HIDX  = HIDX_WIDTH'(HEADER_FLITS - 1);
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(CREDIT_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [HDR_PAD_WIDTH-1:0] hdr_q;
    logic [VC_WIDTH-1:0]      vc_q;
    logic                     has_payload_q;
    logic [BEAT_WIDTH-1:0]    beats_q;
    logic [HIDX_WIDTH-1:0]    hidx_q;
    logic                     ready_en_q;
    logic [CREDIT_WIDTH-1:0]  credit_q [VIRTUAL_CHANNELS];

    logic                       credit_ok;
    logic                       header_fire;
    logic                       flit_fire;
    logic                       last_chunk;
    logic                       last_beat;
    logic [FLIT_DATA_WIDTH-1:0] flit_data;
    logic                       flit_tail;
    logic                       flit_head;
    logic                       flit_type;
    logic [VIRTUAL_CHANNELS-1:0] credit_take;

    // Only bit 6 of the packet type (payload present) matters here.
    logic unused_type_bits;
    assign unused_type_bits = ^{i_packet_type[7], i_packet_type[5:0]};

    assign credit_ok   = (credit_q[vc_q] != '0);
    assign header_fire = i_header_valid && o_header_ready;
    assign flit_fire   = o_flit_valid && i_flit_ready;
    assign last_chunk  = (hidx_q == LAST_HIDX);
    assign last_beat   = (beats_q == BEAT_WIDTH'(1));
    assign o_flit      = {flit_data, flit_tail, flit_head, flit_type};

    // State register; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Header acceptance is held off for the first cycle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // Next state, handshakes and flit formatting.
    always_comb begin
        state_d         = state_q;
        o_header_ready  = 1'b0;
        o_payload_ready = 1'b0;
        o_flit_valid    = 1'b0;
        o_vc            = '0;
        flit_data       = '0;
        flit_tail       = 1'b0;
        flit_head       = 1'b0;
        flit_type       = 1'b0;

        unique case (state_q)
            IDLE: begin
                o_header_ready = ready_en_q;
                if (i_header_valid && ready_en_q) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                o_vc         = vc_q;
                o_flit_valid = credit_ok;
                flit_data    = hdr_q[hidx_q * FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
                flit_head    = (hidx_q == '0);
                flit_tail    = last_chunk && !has_payload_q;
                if (flit_fire && last_chunk) begin
                    state_d = has_payload_q ? PAYLOAD : IDLE;
                end
            end
            PAYLOAD: begin
                o_vc            = vc_q;
                o_flit_valid    = i_payload_valid && credit_ok;
                o_payload_ready = i_flit_ready && credit_ok;
                flit_data       = FLIT_DATA_WIDTH'(i_payload);
                flit_type       = 1'b1;
                flit_tail       = last_beat;
                if (flit_fire && last_beat) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Packet context: header image, VC, payload flag, chunk index and beats left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q         <= '0;
            vc_q          <= '0;
            has_payload_q <= 1'b0;
            beats_q       <= '0;
            hidx_q        <= '0;
        end else if (header_fire) begin
            hdr_q         <= HDR_PAD_WIDTH'(i_header);
            vc_q          <= i_vc;
            has_payload_q <= i_packet_type[6];
            // A zero burst length encodes the full 2^BURST_LENGTH_WIDTH beats.
            beats_q       <= {(i_burst_length == '0), i_burst_length};
            hidx_q        <= '0;
        end else if (flit_fire) begin
            if (state_q == HEADER) begin
                hidx_q <= hidx_q + HIDX_WIDTH'(1);
            end else if (state_q == PAYLOAD) begin
                beats_q <= beats_q - BEAT_WIDTH'(1);
            end
        end
    end

    // A fired flit takes one credit from the current VC.
    always_comb begin
        credit_take = '0;
        for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
            credit_take[v] = flit_fire && (vc_q == VC_WIDTH'(v));
        end
    end

    // Per-VC credit counters; a simultaneous take and return cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
                credit_q[v] <= CREDIT_MAX;
            end
        end else begin
            for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
                if (i_credit_return[v] && !credit_take[v]) begin
                    if (credit_q[v] != CREDIT_MAX) begin
                        credit_q[v] <= credit_q[v] + CREDIT_WIDTH'(1);
                    end
                end else if (credit_take[v] && !i_credit_return[v]) begin
                    credit_q[v] <= credit_q[v] - CREDIT_WIDTH'(1);
                end
            end
        end
    end

    // A credit returned to a full counter means downstream accounting is broken.
    for (genvar gv = 0; gv < VIRTUAL_CHANNELS; gv++) begin : g_credit_chk
        a_credit_overflow: assert property (@(posedge clk) disable iff (!rst_n)
            !(i_credit_return[gv] && !credit_take[gv] && (credit_q[gv] == CREDIT_MAX)))
            else $error("credit return overflow on vc %0d", gv);
    end

endmodule

// File: tb/tb_tnoc_flit_packer.sv
// Bench for tnoc_flit_packer: a two-chunk header configuration with a small
// credit pool, checked against a flit-list reference model.
module tb_tnoc_flit_packer;

    localparam int unsigned VCS = 2;
    localparam int unsigned HW  = 120;
    localparam int unsigned FDW = 64;
    localparam int unsigned PW  = 48;
    localparam int unsigned BLW = 8;
    localparam int unsigned CD  = 2;
    localparam int unsigned VCW = 1;
    localparam int unsigned FW  = FDW + 3;
    localparam int unsigned HF  = (HW + FDW - 1) / FDW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_header_valid = 1'b0;
    logic           o_header_ready;
    logic [7:0]     i_packet_type = '0;
    logic [BLW-1:0] i_burst_length = '0;
    logic [VCW-1:0] i_vc = '0;
    logic [HW-1:0]  i_header = '0;
    logic           i_payload_valid = 1'b0;
    logic           o_payload_ready;
    logic [PW-1:0]  i_payload = '0;
    logic           o_flit_valid;
    logic           i_flit_ready = 1'b0;
    logic [FW-1:0]  o_flit;
    logic [VCW-1:0] o_vc;
    logic [VCS-1:0] i_credit_return = '0;

    tnoc_flit_packer #(
        .VIRTUAL_CHANNELS  (VCS),
        .HEADER_WIDTH      (HW),
        .FLIT_DATA_WIDTH   (FDW),
        .PAYLOAD_WIDTH     (PW),
        .BURST_LENGTH_WIDTH(BLW),
        .CREDIT_DEPTH      (CD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_header_valid (i_header_valid),
        .o_header_ready (o_header_ready),
        .i_packet_type  (i_packet_type),
        .i_burst_length (i_burst_length),
        .i_vc           (i_vc),
        .i_header       (i_header),
        .i_payload_valid(i_payload_valid),
        .o_payload_ready(o_payload_ready),
        .i_payload      (i_payload),
        .o_flit_valid   (o_flit_valid),
        .i_flit_ready   (i_flit_ready),
        .o_flit         (o_flit),
        .o_vc           (o_vc),
        .i_credit_return(i_credit_return)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [FW-1:0]  flit;
        logic [VCW-1:0] vc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          pend_exp[$];
    logic [PW-1:0] pay_q[$];
    logic [PW-1:0] pend_pay[$];
    int            cred_m [VCS];

    int checks = 0;
    int failures = 0;
    int ready_pct = 100;
    int pv_pct = 100;
    int ret_pct = 100;
    logic [VCS-1:0] force_ret = '0;
    bit hdr_pending = 1'b0;
    bit prev_stall = 1'b0;
    bit hf_prev = 1'b0;
    logic [FW-1:0]  prev_flit = '0;
    logic [VCW-1:0] prev_vc = '0;
    int flit_fires = 0;
    int payload_fires = 0;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Build the expected flit list for one packet and present its header.
    task automatic queue_packet(input logic [7:0] ptype, input logic [BLW-1:0] blen,
                                input logic [VCW-1:0] vc);
        logic [HW-1:0]     h;
        logic [HF*FDW-1:0] hp;
        logic [PW-1:0]     b;
        exp_t              e;
        int                nb;
        h  = HW'({$urandom(), $urandom(), $urandom(), $urandom()});
        hp = (HF * FDW)'(h);
        pend_exp.delete();
        pend_pay.delete();
        for (int c = 0; c < HF; c++) begin
            e.flit = {hp[c*FDW +: FDW], 1'((c == HF - 1) && !ptype[6]), 1'(c == 0), 1'b0};
            e.vc   = vc;
            pend_exp.push_back(e);
        end
        if (ptype[6]) begin
            nb = (blen == 0) ? (1 << BLW) : int'(blen);
            for (int k = 0; k < nb; k++) begin
                b      = PW'({$urandom(), $urandom()});
                e.flit = {FDW'(b), 1'(k == nb - 1), 1'b0, 1'b1};
                e.vc   = vc;
                pend_exp.push_back(e);
                pend_pay.push_back(b);
            end
        end
        i_packet_type  = ptype;
        i_burst_length = blen;
        i_vc           = vc;
        i_header       = h;
        hdr_pending    = 1'b1;
    endtask

    // One clock: drive at posedge+1, check at posedge+2, advance model.
    task automatic cycle();
        bit   fire;
        bit   hf;
        bit   phs;
        bit   exp_phs;
        exp_t e;
        i_header_valid = hdr_pending;
        if (!i_payload_valid) begin
            i_payload_valid = (pay_q.size() > 0) && ($urandom_range(0, 99) < pv_pct);
        end
        i_payload    = (pay_q.size() > 0) ? pay_q[0] : '0;
        i_flit_ready = ($urandom_range(0, 99) < ready_pct);
        for (int v = 0; v < VCS; v++) begin
            i_credit_return[v] = (force_ret[v] || ($urandom_range(0, 99) < ret_pct))
                                 && (cred_m[v] < CD);
        end
        force_ret = '0;
        #1;
        chk("header_ready", FW'(o_header_ready), FW'(exp_q.size() == 0));
        if (o_flit_valid) begin
            chk("credit_gate", FW'(cred_m[o_vc] != 0), FW'(1'b1));
        end
        if (prev_stall) begin
            chk("hold_valid", FW'(o_flit_valid), FW'(1'b1));
            chk("hold_flit", o_flit, prev_flit);
            chk("hold_vc", FW'(o_vc), FW'(prev_vc));
        end
        if (hf_prev && exp_q.size() > 0) begin
            if (cred_m[exp_q[0].vc] != 0) begin
                chk("first_flit_latency", FW'(o_flit_valid), FW'(1'b1));
            end
        end
        if (exp_q.size() == 0) begin
            chk("idle_valid", FW'(o_flit_valid), FW'(1'b0));
            chk("idle_flit", o_flit, FW'(0));
        end
        fire    = o_flit_valid && i_flit_ready;
        phs     = i_payload_valid && o_payload_ready;
        exp_phs = fire && (exp_q.size() > 0) && exp_q[0].flit[0];
        chk("payload_handshake", FW'(phs), FW'(exp_phs));
        if (fire) begin
            flit_fires++;
            if (exp_q.size() == 0) begin
                chk("spurious_flit", FW'(o_flit_valid), FW'(1'b0));
            end else begin
                e = exp_q.pop_front();
                chk("flit", o_flit, e.flit);
                chk("flit_vc", FW'(o_vc), FW'(e.vc));
            end
        end
        if (phs) begin
            payload_fires++;
            void'(pay_q.pop_front());
        end
        hf = i_header_valid && o_header_ready;
        if (hf) begin
            foreach (pend_exp[i]) exp_q.push_back(pend_exp[i]);
            foreach (pend_pay[i]) pay_q.push_back(pend_pay[i]);
            hdr_pending = 1'b0;
        end
        for (int v = 0; v < VCS; v++) begin
            cred_m[v] = cred_m[v] + int'(i_credit_return[v]) - int'(fire && (o_vc == VCW'(v)));
        end
        prev_stall = o_flit_valid && !i_flit_ready;
        prev_flit  = o_flit;
        prev_vc    = o_vc;
        hf_prev    = hf;
        @(posedge clk);
        #1;
        if (phs) i_payload_valid = 1'b0;
        if (hf) i_header_valid = 1'b0;
    endtask

    task automatic drain(input int budget, output int used);
        used = 0;
        while ((hdr_pending || exp_q.size() != 0) && used < budget) begin
            cycle();
            used++;
        end
        if (hdr_pending || exp_q.size() != 0) begin
            chk("drain_timeout", FW'(exp_q.size()), FW'(0));
        end
    endtask

    task automatic refill();
        int n = 0;
        int saved = ret_pct;
        ret_pct = 100;
        while ((cred_m[0] < CD || cred_m[1] < CD) && n < 20) begin
            cycle();
            n++;
        end
        ret_pct = saved;
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend_exp.delete();
        pay_q.delete();
        pend_pay.delete();
        for (int v = 0; v < VCS; v++) cred_m[v] = CD;
        hdr_pending     = 1'b0;
        prev_stall      = 1'b0;
        hf_prev         = 1'b0;
        i_header_valid  = 1'b0;
        i_payload_valid = 1'b0;
        i_flit_ready    = 1'b0;
        i_credit_return = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_header_ready"}, FW'(o_header_ready), FW'(0));
        chk({tag, "_payload_ready"}, FW'(o_payload_ready), FW'(0));
        chk({tag, "_flit_valid"}, FW'(o_flit_valid), FW'(0));
        chk({tag, "_flit"}, o_flit, FW'(0));
        chk({tag, "_vc"}, FW'(o_vc), FW'(0));
    endtask

    initial begin
        int used;
        int base_f;
        int base_p;
        int n;
        logic [7:0] types [5];
        types = '{8'h10, 8'h40, 8'h41, 8'h80, 8'hC0};

        // Reset state, then the one-cycle hold-off of header ready.
        model_reset();
        rst_n = 1'b0;
        #2;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", FW'(o_header_ready), FW'(0));
        @(posedge clk);
        #1;
        chk("ready_after_reset", FW'(o_header_ready), FW'(1'b1));

        // Read on vc1: two header chunks, no payload, tail on the second.
        ready_pct = 100; pv_pct = 100; ret_pct = 0;
        queue_packet(8'h10, BLW'(5), 1'b1);
        drain(50, used);
        chk("read_cycles", FW'(used), FW'(3));
        refill();

        // Posted write, 4 beats, credits recycled every cycle: no gaps.
        ret_pct = 100;
        base_p  = payload_fires;
        queue_packet(8'h40, BLW'(4), 1'b0);
        drain(50, used);
        chk("write_cycles", FW'(used), FW'(7));
        chk("write_beats", FW'(payload_fires - base_p), FW'(4));
        refill();

        // Credit exhaustion on vc0, then a single returned credit.
        ret_pct = 0;
        base_f  = flit_fires;
        queue_packet(8'h41, BLW'(4), 1'b0);
        repeat (8) cycle();
        chk("stall_fires", FW'(flit_fires - base_f), FW'(2));
        chk("stall_valid", FW'(o_flit_valid), FW'(0));
        force_ret = 2'b01;
        base_f    = flit_fires;
        repeat (6) cycle();
        chk("one_credit_one_flit", FW'(flit_fires - base_f), FW'(1));
        ret_pct = 50;
        drain(200, used);
        refill();

        // 256-beat response with data and a 3-cycle downstream stall mid-burst.
        ret_pct = 100;
        base_p  = payload_fires;
        queue_packet(8'hC0, BLW'(0), 1'b1);
        repeat (60) cycle();
        ready_pct = 0;
        repeat (3) cycle();
        ready_pct = 100;
        drain(2000, used);
        chk("burst256_beats", FW'(payload_fires - base_p), FW'(256));
        refill();

        // Reset while payload beat 2 is on the output.
        base_p = payload_fires;
        queue_packet(8'h40, BLW'(4), 1'b0);
        n = 0;
        while (payload_fires - base_p < 1 && n < 20) begin
            cycle();
            n++;
        end
        chk("pre_reset_beat", FW'(payload_fires - base_p), FW'(1));
        chk("pre_reset_valid", FW'(o_flit_valid), FW'(1'b1));
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_midreset", FW'(o_header_ready), FW'(1'b1));
        ret_pct = 0;
        queue_packet(8'h80, BLW'(3), 1'($urandom_range(0, 1)));
        drain(50, used);
        chk("post_reset_read_cycles", FW'(used), FW'(3));

        // Randomized traffic with random backpressure and credit returns.
        ready_pct = 60; pv_pct = 70; ret_pct = 30;
        for (int p = 0; p < 25; p++) begin
            repeat ($urandom_range(0, 3)) cycle();
            queue_packet(types[$urandom_range(0, 4)], BLW'($urandom_range(1, 12)),
                         1'($urandom_range(0, 1)));
            drain(600, used);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
